// File: rtl/vx_tcu_drl_max_exp_pkg.sv
// Shared helpers for the DRL tensor-core max-exponent / alignment stage.
package vx_tcu_drl_max_exp_pkg;

  // Zero-term marker: the most negative signed exponent of the given width.
  function automatic logic [31:0] exp_neg_inf(input int exp_w);
    return 32'd1 << (exp_w - 1);
  endfunction

  function automatic int drl_shift_w(input int wa);
    return $clog2(wa + 1);
  endfunction

endpackage

// File: rtl/vx_tcu_drl_max_exp_max_tree.sv
// Combinational signed max reduction over T exponents, log-depth tree.
// Unused leaves of the power-of-two tree are padded with NEG_INF so they never win.
module vx_tcu_drl_max_exp_max_tree
  import vx_tcu_drl_max_exp_pkg::*;
#(
  parameter int T     = 5,
  parameter int EXP_W = 10
) (
  input  logic [T*EXP_W-1:0] exps,
  output logic [EXP_W-1:0]   max_exp
);

  localparam int LEVELS = (T > 1) ? $clog2(T) : 0;
  localparam int P      = 1 << LEVELS;
  localparam logic [EXP_W-1:0] NEG_INF = EXP_W'(exp_neg_inf(EXP_W));

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = P >> l;
    logic [EXP_W-1:0] v [W];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < W; i++) begin : g_in
        if (i < T) begin : g_real
          assign v[i] = exps[i*EXP_W +: EXP_W];
        end else begin : g_pad
          assign v[i] = NEG_INF;
        end
      end
    end else begin : g_red
      for (genvar i = 0; i < W; i++) begin : g_node
        assign v[i] = ($signed(g_lvl[l-1].v[2*i]) >= $signed(g_lvl[l-1].v[2*i+1]))
                    ? g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign max_exp = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/vx_tcu_drl_max_exp.sv
// Two-stage elastic max-exponent / alignment-shift stage of the DRL FEDP datapath.
// Optional saturation counter enabled by defining TCU_DRL_SAT_PERF_EN.
module vx_tcu_drl_max_exp
  import vx_tcu_drl_max_exp_pkg::*;
#(
  parameter int N       = 2,
  parameter int TCK     = 2 * N,
  parameter int EXP_W   = 10,
  parameter int WA      = 28,
  parameter int SHIFT_W = drl_shift_w(WA),
  parameter int TAG_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [(TCK+1)*EXP_W-1:0]     raw_exp_y,
  input  logic [TCK*6-1:0]             exp_diff_f8,
  input  logic [TAG_W-1:0]             tag_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [EXP_W-1:0]             max_exp,
  output logic [(TCK+1)*SHIFT_W-1:0]   shift_amt,
  output logic [TCK:0]                 term_zero,
  output logic                         all_zero,
  output logic [TCK*6-1:0]             exp_diff_f8_out,
  output logic [TAG_W-1:0]             tag_out,
  output logic [31:0]                  perf_sat_cnt
);

  localparam int T = TCK + 1;
  localparam logic [EXP_W-1:0]   NEG_INF = EXP_W'(exp_neg_inf(EXP_W));
  localparam logic [EXP_W:0]     WA_D    = (EXP_W+1)'(WA);
  localparam logic [SHIFT_W-1:0] WA_S    = SHIFT_W'(WA);

  // Handshake: each stage is a pipe register that loads when it is empty or
  // when the stage after it is taking its contents this cycle. Transfer
  // happens on a rising clk edge whenever valid and ready are both high.
  logic ld_1, ld_2;
  logic valid_1, valid_2;

  assign ld_2     = ~valid_2 | ready_out;
  assign ld_1     = ~valid_1 | ld_2;
  assign ready_in = ld_1;

  // ---------------- stage 1: max reduction ----------------
  logic [EXP_W-1:0]   max_c;
  logic [EXP_W-1:0]   max_1;
  logic [T*EXP_W-1:0] exps_1;
  logic [TCK*6-1:0]   f8_1;
  logic [TAG_W-1:0]   tag_1;

  vx_tcu_drl_max_exp_max_tree #(
    .T     (T),
    .EXP_W (EXP_W)
  ) u_max_tree (
    .exps    (raw_exp_y),
    .max_exp (max_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_1 <= 1'b0;
      max_1   <= '0;
      exps_1  <= '0;
      f8_1    <= '0;
      tag_1   <= '0;
    end else begin
      if (ld_1) valid_1 <= valid_in;
      if (ld_1 && valid_in) begin
        max_1  <= max_c;
        exps_1 <= raw_exp_y;
        f8_1   <= exp_diff_f8;
        tag_1  <= tag_in;
      end
    end
  end

  // ---------------- stage 2: differences and saturation ----------------
  logic [EXP_W:0]       diff_c [T];
  logic [T-1:0]         tz_c;
  logic [T-1:0]         sat_c;
  logic [T*SHIFT_W-1:0] shift_c;

  always_comb begin
    diff_c  = '{default: '0};
    tz_c    = '0;
    sat_c   = '0;
    shift_c = '0;
    for (int i = 0; i < T; i++) begin
      // Sign-extend by one bit so max - exp never wraps, even NEG_INF vs positive max.
      diff_c[i] = {max_1[EXP_W-1], max_1} -
                  {exps_1[i*EXP_W + EXP_W-1], exps_1[i*EXP_W +: EXP_W]};
      tz_c[i]   = (exps_1[i*EXP_W +: EXP_W] == NEG_INF);
      sat_c[i]  = (diff_c[i] >= WA_D);
      shift_c[i*SHIFT_W +: SHIFT_W] = (tz_c[i] || sat_c[i]) ? WA_S : diff_c[i][SHIFT_W-1:0];
    end
  end

  logic [EXP_W-1:0]     max_2;
  logic [T*SHIFT_W-1:0] shift_2;
  logic [T-1:0]         tz_2;
  logic                 az_2;
  logic [TCK*6-1:0]     f8_2;
  logic [TAG_W-1:0]     tag_2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_2 <= 1'b0;
      max_2   <= '0;
      shift_2 <= '0;
      tz_2    <= '0;
      az_2    <= 1'b0;
      f8_2    <= '0;
      tag_2   <= '0;
    end else begin
      if (ld_2) valid_2 <= valid_1;
      if (ld_2 && valid_1) begin
        max_2   <= (&tz_c) ? NEG_INF : max_1;
        shift_2 <= shift_c;
        tz_2    <= tz_c;
        az_2    <= &tz_c;
        f8_2    <= f8_1;
        tag_2   <= tag_1;
      end
    end
  end

  assign valid_out       = valid_2;
  assign max_exp         = max_2;
  assign shift_amt       = shift_2;
  assign term_zero       = tz_2;
  assign all_zero        = az_2;
  assign exp_diff_f8_out = f8_2;
  assign tag_out         = tag_2;

`ifdef TCU_DRL_SAT_PERF_EN
  // Saturation among real (non-zero) terms is captured alongside the set and
  // counted only when that set actually leaves the stage.
  logic        sat_2;
  logic [31:0] sat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_2   <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (ld_2 && valid_1) sat_2 <= |(sat_c & ~tz_c);
      if (valid_2 && ready_out && sat_2) sat_cnt <= sat_cnt + 32'd1;
    end
  end

  assign perf_sat_cnt = sat_cnt;
`else
  assign perf_sat_cnt = 32'd0;
`endif

endmodule
